// File: rtl/mux_pattern_checker.sv
// mux_pattern_checker
// Clocked stimulus sequencer and checker for a 2:1 mux (o1 = sel ? b : a).
// Drives the eight {sel, a, b} vectors in ascending order. Each vector is held
// for HOLD_CYCLES clocks, and o1 is sampled on the last of those clocks.
// Reports a saturating error count, the first failing vector and a pass flag.

module mux_pattern_checker #(
   parameter int HOLD_CYCLES = 2,
   parameter int ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             sel_o,
   input  logic             o1_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [2:0]       fail_idx,
   output logic [2:0]       vec_idx
);

   // Hold counter must be at least one bit wide, even when HOLD_CYCLES is 1.
   localparam int               CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
   localparam logic [2:0]       LAST_VEC    = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] hold_cnt_r;

   logic             sample_s;
   logic             exp_s;
   logic             mismatch_s;
   logic [ERR_W-1:0] err_nxt_s;
   logic [2:0]       vec_nxt_s;

   // Golden mux behaviour for a vector index laid out as {sel, a, b}.
   function automatic logic mux_expected(input logic [2:0] vec);
      return vec[2] ? vec[0] : vec[1];
   endfunction

   // Sample strobe, mismatch detection and the next saturating error count.
   always_comb begin
      sample_s   = 1'b0;
      exp_s      = mux_expected(vec_idx);
      mismatch_s = 1'b0;
      err_nxt_s  = err_cnt;
      vec_nxt_s  = vec_idx + 3'd1;
      if ((state_r == ST_DRIVE) && (hold_cnt_r == '0)) begin
         sample_s = 1'b1;
      end else begin
         sample_s = 1'b0;
      end
      if (sample_s && (o1_i != exp_s)) begin
         mismatch_s = 1'b1;
      end else begin
         mismatch_s = 1'b0;
      end
      if (mismatch_s && (err_cnt != ERR_MAX)) begin
         err_nxt_s = err_cnt + ERR_ONE;
      end else begin
         err_nxt_s = err_cnt;
      end
   end

   // Sequencer FSM: stimulus, verdict and status outputs are all registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         hold_cnt_r <= '0;
         vec_idx    <= 3'd0;
         a_o        <= 1'b0;
         b_o        <= 1'b0;
         sel_o      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_idx   <= 3'd0;
      end else begin
         case (state_r)
            // IDLE and DONE accept start identically; a restart wipes the old verdict.
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_r    <= ST_DRIVE;
                  hold_cnt_r <= HOLD_RELOAD;
                  vec_idx    <= 3'd0;
                  a_o        <= 1'b0;
                  b_o        <= 1'b0;
                  sel_o      <= 1'b0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_cnt    <= '0;
                  fail_valid <= 1'b0;
                  fail_idx   <= 3'd0;
               end
            end
            // start is ignored here. The vector is held until the counter
            // expires, then o1 is judged and the sequencer advances.
            ST_DRIVE: begin
               if (sample_s) begin
                  err_cnt <= err_nxt_s;
                  if (mismatch_s && !fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_idx   <= vec_idx;
                  end
                  if (vec_idx != LAST_VEC) begin
                     vec_idx    <= vec_nxt_s;
                     sel_o      <= vec_nxt_s[2];
                     a_o        <= vec_nxt_s[1];
                     b_o        <= vec_nxt_s[0];
                     hold_cnt_r <= HOLD_RELOAD;
                  end else begin
                     state_r <= ST_DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     pass    <= (err_nxt_s == '0);
                  end
               end else begin
                  hold_cnt_r <= hold_cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
               pass    <= 1'b0;
            end
         endcase
      end
   end

endmodule
